// File: rtl/input_event_arbiter.sv
// Merges PS/2 keyboard, PS/2 mouse and USB HID reports into one 32-bit first-word-fall-through event FIFO.
// Optional build macro INPUT_EVT_USB_DEDUP_EN: silently discard a USB report equal to the last emitted one.
module input_event_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int USB_BYTES  = 8
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic [7:0]                    kbd_code_i,
  input  logic                          kbd_strobe_i,
  input  logic                          kbd_err_i,
  input  logic [15:0]                   mouse_x_i,
  input  logic [15:0]                   mouse_y_i,
  input  logic [2:0]                    mouse_btn_i,
  input  logic [USB_BYTES*8-1:0]        usb_report_i,
  input  logic                          usb_valid_i,
  output logic [31:0]                   evt_data_o,
  output logic                          evt_valid_o,
  input  logic                          evt_pop_i,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count_o,
  output logic [7:0]                    drop_count_o,
  input  logic                          drop_clr_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = USB_BYTES * 8;

  typedef enum logic [1:0] {ST_ARB, ST_USB1, ST_USB2} state_e;
  typedef enum logic [1:0] {SRC_KBD = 2'd0, SRC_USB = 2'd1, SRC_MOUSE = 2'd2} src_e;

  function automatic src_e next_src(src_e s);
    case (s)
      SRC_KBD: return SRC_USB;
      SRC_USB: return SRC_MOUSE;
      default: return SRC_KBD;
    endcase
  endfunction

  function automatic logic [31:0] usb_word(logic [1:0] part, logic [RW-1:0] rep);
    case (part)
      2'd0:    return {SRC_USB, 1'b0, 5'd0, rep[23:0]};
      2'd1:    return {SRC_USB, 1'b0, 5'd1, rep[47:24]};
      default: return {SRC_USB, 1'b0, 5'd2, 8'd0, rep[63:48]};
    endcase
  endfunction

  state_e            state_q, state_d;
  src_e              rr_q, rr_d;
  logic              kbd_pend_q, kbd_pend_d, kbd_err_q, kbd_err_d;
  logic [7:0]        kbd_code_q, kbd_code_d;
  logic              mouse_pend_q, mouse_pend_d;
  logic [15:0]       mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
  logic [2:0]        mouse_btn_q, mouse_btn_d;
  logic              usb_pend_q, usb_pend_d;
  logic [RW-1:0]     usb_rep_q, usb_rep_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        drop_q, drop_d;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic [2:0]        src_ok;
  logic              grant_vld, push, pop, usb_grant, usb_busy, usb_dup;
  logic              kbd_drop, usb_drop;
  src_e              grant_src, cand;
  logic [31:0]       push_word;
  logic [8:0]        drop_sum;

`ifdef INPUT_EVT_USB_DEDUP_EN
  logic [RW-1:0] last_rep_q, last_rep_d;
  assign last_rep_d = usb_grant ? usb_rep_q : last_rep_q;
  assign usb_dup    = (usb_report_i == last_rep_q);
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) last_rep_q <= '0;
    else         last_rep_q <= last_rep_d;
  end
`else
  assign usb_dup = 1'b0;
`endif

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;  rr_d = rr_q;
    kbd_pend_d = kbd_pend_q;  kbd_code_d = kbd_code_q;  kbd_err_d = kbd_err_q;
    mouse_pend_d = mouse_pend_q;  mouse_x_d = mouse_x_q;  mouse_y_d = mouse_y_q;  mouse_btn_d = mouse_btn_q;
    usb_pend_d = usb_pend_q;  usb_rep_d = usb_rep_q;
    push = 1'b0;  push_word = '0;  usb_grant = 1'b0;  kbd_drop = 1'b0;  usb_drop = 1'b0;

    // Space checks look at the registered count only; a same-cycle pop does not help.
    src_ok[SRC_KBD]   = kbd_pend_q   && (count_q < CW'(FIFO_DEPTH));
    src_ok[SRC_MOUSE] = mouse_pend_q && (count_q < CW'(FIFO_DEPTH));
    src_ok[SRC_USB]   = usb_pend_q   && ((CW'(FIFO_DEPTH) - count_q) >= CW'(3));

    grant_vld = 1'b0;  grant_src = SRC_KBD;  cand = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!grant_vld && src_ok[cand]) begin
        grant_vld = 1'b1;
        grant_src = cand;
      end
      cand = next_src(cand);
    end

    unique case (state_q)
      ST_ARB: if (grant_vld) begin
        push = 1'b1;
        rr_d = next_src(grant_src);
        case (grant_src)
          SRC_KBD: begin
            push_word  = {SRC_KBD, kbd_err_q, 5'd0, 16'd0, kbd_code_q};
            kbd_pend_d = 1'b0;
          end
          SRC_USB: begin
            push_word = usb_word(2'd0, usb_rep_q);
            usb_grant = 1'b1;
            rr_d      = rr_q;
            state_d   = ST_USB1;
          end
          default: begin
            push_word    = {SRC_MOUSE, 1'b0, 5'd0, 5'd0, mouse_btn_q, mouse_x_q[7:0], mouse_y_q[7:0]};
            mouse_pend_d = 1'b0;
          end
        endcase
      end
      ST_USB1: begin
        push = 1'b1;  push_word = usb_word(2'd1, usb_rep_q);  state_d = ST_USB2;
      end
      ST_USB2: begin
        push = 1'b1;  push_word = usb_word(2'd2, usb_rep_q);  state_d = ST_ARB;
        usb_pend_d = 1'b0;  rr_d = next_src(SRC_USB);
      end
      default: state_d = ST_ARB;
    endcase

    // Captures see the cleared pend flags, so a new event in the clearing cycle is kept.
    if (kbd_strobe_i) begin
      if (kbd_pend_d) kbd_drop = 1'b1;
      else begin
        kbd_pend_d = 1'b1;  kbd_code_d = kbd_code_i;  kbd_err_d = kbd_err_i;
      end
    end
    if ({mouse_x_i, mouse_y_i, mouse_btn_i} != {mouse_x_q, mouse_y_q, mouse_btn_q}) begin
      mouse_pend_d = 1'b1;  mouse_x_d = mouse_x_i;  mouse_y_d = mouse_y_i;  mouse_btn_d = mouse_btn_i;
    end
    usb_busy = (state_q != ST_ARB) || usb_grant;
    if (usb_valid_i && !usb_dup) begin
      if (usb_busy) usb_drop = 1'b1;
      else begin
        usb_pend_d = 1'b1;  usb_rep_d = usb_report_i;
      end
    end

    pop      = evt_pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    drop_sum = {1'b0, drop_q} + {8'd0, kbd_drop} + {8'd0, usb_drop};
    if (drop_clr_i)       drop_d = '0;
    else if (drop_sum[8]) drop_d = 8'hFF;
    else                  drop_d = drop_sum[7:0];
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_ARB;  rr_q <= SRC_KBD;
      kbd_pend_q <= 1'b0;  kbd_code_q <= '0;  kbd_err_q <= 1'b0;
      mouse_pend_q <= 1'b0;  mouse_x_q <= '0;  mouse_y_q <= '0;  mouse_btn_q <= '0;
      usb_pend_q <= 1'b0;  usb_rep_q <= '0;
      wr_ptr_q <= '0;  rd_ptr_q <= '0;  count_q <= '0;  drop_q <= '0;
    end else begin
      state_q <= state_d;  rr_q <= rr_d;
      kbd_pend_q <= kbd_pend_d;  kbd_code_q <= kbd_code_d;  kbd_err_q <= kbd_err_d;
      mouse_pend_q <= mouse_pend_d;  mouse_x_q <= mouse_x_d;  mouse_y_q <= mouse_y_d;  mouse_btn_q <= mouse_btn_d;
      usb_pend_q <= usb_pend_d;  usb_rep_q <= usb_rep_d;
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;  drop_q <= drop_d;
    end
  end

  // NOTE: storage is not reset; the head is masked to zero while the FIFO is empty instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign evt_valid_o  = (count_q != '0);
  assign evt_data_o   = evt_valid_o ? mem_q[rd_ptr_q] : '0;
  assign evt_count_o  = count_q;
  assign drop_count_o = drop_q;
endmodule

// File: tb/tb_input_event_arbiter.sv
// Self-checking bench for input_event_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_input_event_arbiter;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef INPUT_EVT_USB_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  localparam logic [63:0] R2 = 64'h0011_2233_4455_6677;
  localparam logic [63:0] R3 = 64'h8877_6655_4433_2211;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [7:0]    kbd_code_i;
  logic          kbd_strobe_i, kbd_err_i;
  logic [15:0]   mouse_x_i, mouse_y_i;
  logic [2:0]    mouse_btn_i;
  logic [63:0]   usb_report_i;
  logic          usb_valid_i;
  logic [31:0]   evt_data_o;
  logic          evt_valid_o, evt_pop_i;
  logic [CW-1:0] evt_count_o;
  logic [7:0]    drop_count_o;
  logic          drop_clr_i;

  input_event_arbiter #(.FIFO_DEPTH(DEPTH), .USB_BYTES(8)) dut (
    .clk(clk), .reset_i(reset_i),
    .kbd_code_i(kbd_code_i), .kbd_strobe_i(kbd_strobe_i), .kbd_err_i(kbd_err_i),
    .mouse_x_i(mouse_x_i), .mouse_y_i(mouse_y_i), .mouse_btn_i(mouse_btn_i),
    .usb_report_i(usb_report_i), .usb_valid_i(usb_valid_i),
    .evt_data_o(evt_data_o), .evt_valid_o(evt_valid_o), .evt_pop_i(evt_pop_i),
    .evt_count_o(evt_count_o), .drop_count_o(drop_count_o), .drop_clr_i(drop_clr_i)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO as a queue, sources as pending flags, arbitration as an ordered scan.
  logic [31:0] mq[$];
  bit          m_kbd_pend, m_mouse_pend, m_usb_pend;
  logic [31:0] m_kbd_word;
  logic [15:0] m_sx, m_sy;
  logic [2:0]  m_sb;
  logic [63:0] m_usb_rep, m_last;
  int          m_burst, m_rr, m_drop;

  function automatic logic [31:0] usb_part(input logic [63:0] r, input int p);
    if (p == 0) return {2'd1, 1'b0, 5'd0, r[23:0]};
    if (p == 1) return {2'd1, 1'b0, 5'd1, r[47:24]};
    return {2'd1, 1'b0, 5'd2, 8'd0, r[63:48]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_kbd_pend = 0; m_mouse_pend = 0; m_usb_pend = 0; m_kbd_word = '0;
    m_sx = '0; m_sy = '0; m_sb = '0; m_usb_rep = '0; m_last = '0;
    m_burst = 0; m_rr = 0; m_drop = 0;
  endtask

  task automatic model_step();
    int          cnt = mq.size();
    bit          busy = (m_burst != 0);
    bit          push = 0;
    bit          usb_grant = 0;
    logic [31:0] w = '0;
    logic [63:0] old_last = m_last;
    int          inc = 0;
    if (m_burst != 0) begin
      w = usb_part(m_usb_rep, m_burst); push = 1;
      if (m_burst == 2) begin m_burst = 0; m_usb_pend = 0; m_rr = 2; end
      else m_burst = 2;
    end else begin
      for (int k = 0; k < 3; k++) begin
        int s = (m_rr + k) % 3;
        if (s == 0 && m_kbd_pend && cnt < DEPTH) begin
          w = m_kbd_word; push = 1; m_kbd_pend = 0; m_rr = 1; break;
        end
        if (s == 1 && m_usb_pend && DEPTH - cnt >= 3) begin
          w = usb_part(m_usb_rep, 0); push = 1; usb_grant = 1; m_burst = 1; m_last = m_usb_rep; break;
        end
        if (s == 2 && m_mouse_pend && cnt < DEPTH) begin
          w = {2'd2, 1'b0, 5'd0, 5'd0, m_sb, m_sx[7:0], m_sy[7:0]}; push = 1; m_mouse_pend = 0; m_rr = 0; break;
        end
      end
    end
    if (evt_pop_i && cnt > 0) void'(mq.pop_front());
    if (push) mq.push_back(w);
    if (kbd_strobe_i) begin
      if (m_kbd_pend) inc++;
      else begin m_kbd_pend = 1; m_kbd_word = {2'd0, kbd_err_i, 5'd0, 16'd0, kbd_code_i}; end
    end
    if ({mouse_x_i, mouse_y_i, mouse_btn_i} != {m_sx, m_sy, m_sb}) begin
      m_sx = mouse_x_i; m_sy = mouse_y_i; m_sb = mouse_btn_i; m_mouse_pend = 1;
    end
    if (usb_valid_i && !(DEDUP && usb_report_i == old_last)) begin
      if (busy || usb_grant) inc++;
      else begin m_usb_rep = usb_report_i; m_usb_pend = 1; end
    end
    if (drop_clr_i) m_drop = 0;
    else m_drop = (m_drop + inc > 255) ? 255 : m_drop + inc;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, 32'(evt_valid_o), 32'(mq.size() > 0));
    check({tag, ".count"}, 32'(evt_count_o), mq.size());
    check({tag, ".data"},  evt_data_o, (mq.size() > 0) ? mq[0] : 32'd0);
    check({tag, ".drop"},  32'(drop_count_o), m_drop);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    kbd_strobe_i = 0; kbd_code_i = '0; kbd_err_i = 0; usb_valid_i = 0; usb_report_i = '0;
    mouse_x_i = '0; mouse_y_i = '0; mouse_btn_i = '0; evt_pop_i = 0; drop_clr_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(evt_valid_o), 32'd0);
    check("rst.count", 32'(evt_count_o), 32'd0);
    check("rst.data",  evt_data_o, 32'd0);
    check("rst.drop",  32'(drop_count_o), 32'd0);
    model_reset();
    reset_i = 1'b0;
  endtask

  // One clock: apply pulse inputs, advance model and DUT, release pulses, optionally compare.
  task automatic cyc(input bit ks, input logic [7:0] code, input bit ke, input bit uv,
                     input logic [63:0] rep, input bit pop, input bit clr, input bit cmp);
    kbd_strobe_i = ks; kbd_code_i = code; kbd_err_i = ke;
    usb_valid_i = uv; usb_report_i = rep; evt_pop_i = pop; drop_clr_i = clr;
    model_step();
    @(posedge clk); #1;
    kbd_strobe_i = 0; usb_valid_i = 0; evt_pop_i = 0; drop_clr_i = 0;
    if (cmp) compare_model("seq");
  endtask

  task automatic idle(input int n, input bit pop);
    for (int i = 0; i < n; i++) cyc(0, 8'd0, 0, 0, 64'd0, pop, 0, 1);
  endtask

  typedef struct {
    bit          kbd_stb;
    logic [7:0]  code;
    bit          usb_vld;
    logic [63:0] rep;
    logic [15:0] mx, my;
    logic [2:0]  mb;
    bit          pop;
    bit          e_valid;
    logic [31:0] e_data;
    int          e_count;
  } vec_t;

  function automatic vec_t mk(input bit ks, input logic [7:0] c, input bit uv, input logic [63:0] r,
                              input bit p, input bit ev, input logic [31:0] ed, input int ec);
    vec_t v;
    v.kbd_stb = ks; v.code = c; v.usb_vld = uv; v.rep = r;
    v.mx = 16'h0012; v.my = 16'h0034; v.mb = 3'd5;
    v.pop = p; v.e_valid = ev; v.e_data = ed; v.e_count = ec;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    reset_i = 1'b1;
    // Same-cycle kbd + usb + mouse from RR=KBD, then lone kbd, then lone usb burst.
    vecs.push_back(mk(1, 8'h1C, 1, R3, 0, 0, 32'h0,          0));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 1, 32'h0000_001C,  1));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 1, 32'h0000_001C,  2));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 1, 32'h4033_2211,  2));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 1, 32'h4166_5544,  2));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 1, 32'h4200_8877,  2));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 1, 32'h8005_1234,  1));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 0, 32'h0,          0));
    vecs.push_back(mk(1, 8'h1C, 0, 0,  0, 0, 32'h0,          0));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 1, 32'h0000_001C,  1));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 0, 32'h0,          0));
    vecs.push_back(mk(0, 8'h00, 1, R2, 0, 0, 32'h0,          0));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 1, 32'h4055_6677,  1));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 1, 32'h4055_6677,  2));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 1, 32'h4055_6677,  3));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 1, 32'h4122_3344,  2));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 1, 32'h4200_0011,  1));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1, 0, 32'h0,          0));

    do_reset();
    foreach (vecs[i]) begin
      mouse_x_i = vecs[i].mx; mouse_y_i = vecs[i].my; mouse_btn_i = vecs[i].mb;
      cyc(vecs[i].kbd_stb, vecs[i].code, 0, vecs[i].usb_vld, vecs[i].rep, vecs[i].pop, 0, 0);
      check($sformatf("vec%0d.valid", i), 32'(evt_valid_o), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.data", i),  evt_data_o, vecs[i].e_data);
      check($sformatf("vec%0d.count", i), 32'(evt_count_o), vecs[i].e_count);
      check($sformatf("vec%0d.drop", i),  32'(drop_count_o), 32'd0);
    end

    // USB waits for 3 free slots while a keyboard code is granted ahead of it.
    do_reset();
    for (int i = 0; i < DEPTH - 2; i++) cyc(1, 8'(i + 1), 0, 0, 64'd0, 0, 0, 1);
    idle(2, 0);
    check("fill.count", 32'(evt_count_o), DEPTH - 2);
    cyc(1, 8'hAA, 1, 1, R3, 0, 0, 1);
    idle(4, 0);
    check("usb_wait.count", 32'(evt_count_o), DEPTH - 1);
    idle(2, 1);
    idle(5, 0);
    check("usb_after_pop.count", 32'(evt_count_o), DEPTH);

    // Full FIFO: second keyboard code dropped, clear, saturation, clear beats increment.
    cyc(1, 8'h11, 0, 0, 64'd0, 0, 0, 1);
    cyc(1, 8'h22, 0, 0, 64'd0, 0, 0, 1);
    check("kbd_drop.count", 32'(drop_count_o), 32'd1);
    cyc(0, 8'h00, 0, 0, 64'd0, 0, 1, 1);
    check("drop_clr.count", 32'(drop_count_o), 32'd0);
    for (int i = 0; i < 260; i++) cyc(1, 8'h33, 0, 0, 64'd0, 0, 0, 1);
    check("drop_sat.count", 32'(drop_count_o), 32'd255);
    cyc(1, 8'h44, 0, 0, 64'd0, 0, 1, 1);
    check("drop_clr_wins", 32'(drop_count_o), 32'd0);
    idle(DEPTH + 4, 1);
    check("drain.count", 32'(evt_count_o), 32'd0);

    // Same USB report twice, and an all-zero first report.
    do_reset();
    cyc(0, 8'h00, 0, 1, R2, 0, 0, 1);
    idle(6, 0);
    cyc(0, 8'h00, 0, 1, R2, 0, 0, 1);
    idle(6, 0);
    check("dup.count", 32'(evt_count_o), DEDUP ? 32'd3 : 32'd6);
    check("dup.drop",  32'(drop_count_o), 32'd0);
    do_reset();
    cyc(0, 8'h00, 0, 1, 64'd0, 0, 0, 1);
    idle(6, 0);
    check("zero_rep.count", 32'(evt_count_o), DEDUP ? 32'd0 : 32'd3);

    // Reset in the middle of a burst empties the FIFO immediately.
    do_reset();
    cyc(0, 8'h00, 0, 1, R3, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 64'd0, 0, 0, 1);
    reset_i = 1'b1;
    #1;
    check("midburst.count", 32'(evt_count_o), 32'd0);
    check("midburst.valid", 32'(evt_valid_o), 32'd0);
    check("midburst.data",  evt_data_o, 32'd0);

    // Randomized traffic with alternating drain rates.
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int pop_pct = (blk % 2 == 1) ? 80 : 15;
      for (int i = 0; i < 200; i++) begin
        logic [63:0] rep;
        int pick = $urandom_range(0, 3);
        rep = (pick == 0) ? 64'd0 : (pick == 1) ? R2 : {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) begin
          mouse_x_i   = 16'($urandom);
          mouse_y_i   = 16'($urandom_range(0, 3));
          mouse_btn_i = 3'($urandom);
        end
        cyc($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, rep, $urandom_range(0, 99) < pop_pct,
            $urandom_range(0, 49) == 0, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
